// File: rtl/spike_dispatch_unit.sv
// spike_dispatch_unit
// Sits after the neuron potential update stage. Each accepted update is written
// back to neuron state memory one cycle later. Spiking neurons are queued as
// timestamped packets {node_id, neuron_id, ts} for the network interface. The
// unit also keeps the timestep counter and pulses ts_done once a timestep's
// spikes have fully drained after the scheduler's end-of-timestep pulse.

module spike_dispatch_unit #(
  parameter int NEURON_ID_W = 8,
  parameter int NODE_ID_W   = 4,
  parameter int TS_W        = 8,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NODE_ID_W-1:0]              node_id,
  input  logic                              clear,
  input  logic                              eot,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NEURON_ID_W-1:0]            in_neuron_id,
  input  logic                              in_spike,
  input  logic [31:0]                       in_potential,
  output logic                              pot_wr_en,
  output logic [NEURON_ID_W-1:0]            pot_wr_addr,
  output logic [31:0]                       pot_wr_data,
  output logic                              pkt_valid,
  input  logic                              pkt_ready,
  output logic [NODE_ID_W+NEURON_ID_W+TS_W-1:0] pkt_data,
  output logic [TS_W-1:0]                   ts_count,
  output logic [15:0]                       spike_count,
  output logic                              ts_done
);

  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PKT_W = NODE_ID_W + NEURON_ID_W + TS_W;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Control state
  state_e state_q, state_d;

  // Spike FIFO: pointers carry one extra wrap bit to tell full from empty
  logic [PKT_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PKT_W-1:0] fifo_mem_d [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  // Write-back port registers
  logic                   pot_wr_en_q,   pot_wr_en_d;
  logic [NEURON_ID_W-1:0] pot_wr_addr_q, pot_wr_addr_d;
  logic [31:0]            pot_wr_data_q, pot_wr_data_d;

  // Timestep and spike counters
  logic [TS_W-1:0] ts_count_q,    ts_count_d;
  logic [15:0]     spike_count_q, spike_count_d;

  // Internal handshake decodes
  logic fifo_full_s;
  logic fifo_empty_s;
  logic accept_s;
  logic push_s;
  logic pop_s;
  logic [PKT_W-1:0] push_word_s;

  // Handshake and FIFO status decode; in_ready depends only on registered state
  always_comb begin
    fifo_empty_s = (wr_ptr_q == rd_ptr_q);
    fifo_full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    in_ready     = (state_q == ST_ACCEPT) && !fifo_full_s;
    accept_s     = in_valid && in_ready;
    push_s       = accept_s && in_spike;
    pkt_valid    = !fifo_empty_s;
    pop_s        = pkt_valid && pkt_ready;
    push_word_s  = {node_id, in_neuron_id, ts_count_q};
    pkt_data     = fifo_mem_q[rd_ptr_q[AW-1:0]];
  end

  // Next-state logic for the accept / drain / done sequence
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCEPT: begin
        if (eot) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_ACCEPT;
        end
      end
      ST_DRAIN: begin
        // Evaluated at least once, so an empty FIFO still costs one drain cycle
        if (fifo_empty_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_ACCEPT;
      end
      default: begin
        state_d = ST_ACCEPT;
      end
    endcase
  end

  // FIFO storage and pointer updates; push and pop may share a cycle
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push_s) begin
      fifo_mem_d[wr_ptr_q[AW-1:0]] = push_word_s;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Write-back strobe for every accepted update; address/data hold otherwise
  always_comb begin
    pot_wr_en_d   = 1'b0;
    pot_wr_addr_d = pot_wr_addr_q;
    pot_wr_data_d = pot_wr_data_q;
    if (accept_s) begin
      pot_wr_en_d   = 1'b1;
      pot_wr_addr_d = in_neuron_id;
      pot_wr_data_d = in_potential;
    end else begin
      pot_wr_en_d   = 1'b0;
    end
  end

  // Counters: clear advances the timestep and restarts spike counting, and a
  // spike accepted alongside clear belongs to the old timestep so is not counted
  always_comb begin
    ts_count_d    = ts_count_q;
    spike_count_d = spike_count_q;
    if (clear) begin
      ts_count_d    = ts_count_q + TS_W'(1);
      spike_count_d = 16'h0000;
    end else if (push_s && (spike_count_q != 16'hFFFF)) begin
      spike_count_d = spike_count_q + 16'h0001;
    end else begin
      spike_count_d = spike_count_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_ACCEPT;
      fifo_mem_q    <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      pot_wr_en_q   <= 1'b0;
      pot_wr_addr_q <= '0;
      pot_wr_data_q <= 32'h0000_0000;
      ts_count_q    <= '0;
      spike_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      fifo_mem_q    <= fifo_mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      pot_wr_en_q   <= pot_wr_en_d;
      pot_wr_addr_q <= pot_wr_addr_d;
      pot_wr_data_q <= pot_wr_data_d;
      ts_count_q    <= ts_count_d;
      spike_count_q <= spike_count_d;
    end
  end

  // Output mapping from registered state
  always_comb begin
    pot_wr_en   = pot_wr_en_q;
    pot_wr_addr = pot_wr_addr_q;
    pot_wr_data = pot_wr_data_q;
    ts_count    = ts_count_q;
    spike_count = spike_count_q;
    ts_done     = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_spike_dispatch_unit.sv
// Directed bench for spike_dispatch_unit with hand-computed expectations.
`timescale 1ns/1ps

module tb_spike_dispatch_unit;

  logic        clk;
  logic        reset;
  logic [3:0]  node_id;
  logic        clear;
  logic        eot;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_neuron_id;
  logic        in_spike;
  logic [31:0] in_potential;
  logic        pot_wr_en;
  logic [7:0]  pot_wr_addr;
  logic [31:0] pot_wr_data;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [19:0] pkt_data;
  logic [7:0]  ts_count;
  logic [15:0] spike_count;
  logic        ts_done;

  int n_vec;
  int n_bad;

  spike_dispatch_unit #(
    .NEURON_ID_W(8), .NODE_ID_W(4), .TS_W(8), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .reset(reset), .node_id(node_id), .clear(clear), .eot(eot),
    .in_valid(in_valid), .in_ready(in_ready), .in_neuron_id(in_neuron_id),
    .in_spike(in_spike), .in_potential(in_potential),
    .pot_wr_en(pot_wr_en), .pot_wr_addr(pot_wr_addr), .pot_wr_data(pot_wr_data),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
    .ts_count(ts_count), .spike_count(spike_count), .ts_done(ts_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pkt(input logic [7:0] id, input logic [7:0] ts);
    logic [19:0] w;
    w = {4'd3, id, ts};
    return 32'(w);
  endfunction

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1; node_id = 4'd3; clear = 1'b0; eot = 1'b0;
    in_valid = 1'b0; in_neuron_id = 8'd0; in_spike = 1'b0;
    in_potential = 32'h0; pkt_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_in_ready",  32'(in_ready),    32'd1);
    check("rst_pkt_valid", 32'(pkt_valid),   32'd0);
    check("rst_wr_en",     32'(pot_wr_en),   32'd0);
    check("rst_wr_addr",   32'(pot_wr_addr), 32'd0);
    check("rst_wr_data",   pot_wr_data,      32'd0);
    check("rst_ts",        32'(ts_count),    32'd0);
    check("rst_spk",       32'(spike_count), 32'd0);
    check("rst_ts_done",   32'(ts_done),     32'd0);

    // Spiking update, neuron 5
    in_valid = 1'b1; in_neuron_id = 8'd5; in_spike = 1'b1; in_potential = 32'h3F00_0000;
    tick();
    in_valid = 1'b0;
    check("wb1_en",    32'(pot_wr_en),   32'd1);
    check("wb1_addr",  32'(pot_wr_addr), 32'd5);
    check("wb1_data",  pot_wr_data,      32'h3F00_0000);
    check("pkt1_vld",  32'(pkt_valid),   32'd1);
    check("pkt1_data", 32'(pkt_data),    pkt(8'd5, 8'd0));
    check("spk1",      32'(spike_count), 32'd1);

    // Non-spiking update, neuron 7
    in_valid = 1'b1; in_neuron_id = 8'd7; in_spike = 1'b0; in_potential = 32'h4040_0000;
    tick();
    in_valid = 1'b0;
    check("wb2_en",    32'(pot_wr_en),   32'd1);
    check("wb2_addr",  32'(pot_wr_addr), 32'd7);
    check("wb2_data",  pot_wr_data,      32'h4040_0000);
    check("spk2",      32'(spike_count), 32'd1);
    check("pkt2_head", 32'(pkt_data),    pkt(8'd5, 8'd0));
    tick();
    check("wb_idle",   32'(pot_wr_en),   32'd0);
    pkt_ready = 1'b1;
    tick();
    pkt_ready = 1'b0;
    check("drain1_vld", 32'(pkt_valid), 32'd0);

    // Fill the FIFO with 16 spikes while the link is stalled
    for (int i = 0; i < 16; i++) begin
      check("fill_rdy", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_neuron_id = 8'(i); in_spike = 1'b1; in_potential = 32'(i);
      tick();
    end
    in_valid = 1'b0;
    check("full_rdy", 32'(in_ready),    32'd0);
    check("full_spk", 32'(spike_count), 32'd17);
    // Offered update while full must not be taken
    in_valid = 1'b1; in_neuron_id = 8'hAA; in_spike = 1'b1;
    tick();
    in_valid = 1'b0;
    check("full_nodrop_spk", 32'(spike_count), 32'd17);
    check("full_nodrop_wb",  32'(pot_wr_en),   32'd0);
    pkt_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("order_vld",  32'(pkt_valid), 32'd1);
      check("order_data", 32'(pkt_data),  pkt(8'(i), 8'd0));
      tick();
      if (i == 0) check("rdy_after_pop", 32'(in_ready), 32'd1);
    end
    pkt_ready = 1'b0;
    check("empty_vld", 32'(pkt_valid), 32'd0);

    // Three spikes, then end-of-timestep while stalled
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_neuron_id = 8'(8'h20 + i); in_spike = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    eot = 1'b1;
    tick();
    eot = 1'b0;
    check("drain_rdy",  32'(in_ready), 32'd0);
    check("drain_done", 32'(ts_done),  32'd0);
    pkt_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("drain_data", 32'(pkt_data), pkt(8'(8'h20 + i), 8'd0));
      tick();
    end
    pkt_ready = 1'b0;
    check("drain_last_done", 32'(ts_done),  32'd0);
    check("drain_last_rdy",  32'(in_ready), 32'd0);
    tick();
    check("done_pulse",   32'(ts_done),  32'd1);
    check("done_rdy",     32'(in_ready), 32'd0);
    tick();
    check("done_end",     32'(ts_done),  32'd0);
    check("done_rdy_back", 32'(in_ready), 32'd1);
    check("spk_20",       32'(spike_count), 32'd20);

    // eot with empty FIFO: ts_done two cycles later; eot during DONE is ignored
    eot = 1'b1;
    tick();
    eot = 1'b0;
    check("eot_empty_c1", 32'(ts_done), 32'd0);
    tick();
    check("eot_empty_c2", 32'(ts_done), 32'd1);
    eot = 1'b1;
    tick();
    eot = 1'b0;
    check("eot_in_done_ignored", 32'(in_ready), 32'd1);
    check("eot_in_done_nodone",  32'(ts_done),  32'd0);

    // 255 clears, then a clear coincident with a spiking accept
    for (int i = 0; i < 255; i++) begin
      clear = 1'b1;
      tick();
    end
    clear = 1'b0;
    check("ts_255",   32'(ts_count),    32'd255);
    check("clr_spk0", 32'(spike_count), 32'd0);
    clear = 1'b1; in_valid = 1'b1; in_neuron_id = 8'h44; in_spike = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    check("ts_wrap",       32'(ts_count),    32'd0);
    check("clr_acc_spk",   32'(spike_count), 32'd0);
    check("clr_acc_pkt",   32'(pkt_data),    pkt(8'h44, 8'hFF));

    // Three more spikes -> 4 entries, write-back pending, then reset
    for (int i = 1; i < 4; i++) begin
      in_valid = 1'b1; in_neuron_id = 8'(i); in_spike = 1'b1; in_potential = 32'h1234_0000;
      tick();
    end
    check("pre_rst_spk", 32'(spike_count), 32'd3);
    check("pre_rst_wb",  32'(pot_wr_en),   32'd1);
    reset = 1'b1; in_neuron_id = 8'h09;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    check("mid_rst_vld", 32'(pkt_valid),   32'd0);
    check("mid_rst_wb",  32'(pot_wr_en),   32'd0);
    check("mid_rst_ts",  32'(ts_count),    32'd0);
    check("mid_rst_spk", 32'(spike_count), 32'd0);

    // clear and eot together both act
    clear = 1'b1; eot = 1'b1;
    tick();
    clear = 1'b0; eot = 1'b0;
    check("clr_eot_ts",  32'(ts_count), 32'd1);
    check("clr_eot_rdy", 32'(in_ready), 32'd0);
    tick();
    check("clr_eot_done", 32'(ts_done), 32'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/spike_dispatch_unit.md
Name: spike_dispatch_unit

Overview:
- Downstream of the per-neuron potential update stage; consumes one (neuron_id, spike, final_potential) result per handshake.
- Writes the updated IEEE-754 single-precision potential back to neuron state memory.
- Queues the IDs of spiking neurons in a FIFO and emits timestamped spike packets to the network interface over a valid/ready link.
- Tracks the timestep counter and signals end-of-timestep once all spikes for that timestep have drained.

Parameters:
- NEURON_ID_W, 8, width of neuron index.
- NODE_ID_W, 4, width of local NoC node ID.
- TS_W, 8, width of packet timestamp field.
- FIFO_DEPTH, 16, spike FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- node_id  in  NODE_ID_W  local node ID; sampled at FIFO push.
- clear  in  1  one-cycle pulse marking the start of a new timestep.
- eot  in  1  one-cycle pulse from the scheduler: all neurons of this timestep have been presented.
- in_valid  in  1  update result valid.
- in_ready  out  1  unit can accept an update.
- in_neuron_id  in  NEURON_ID_W  neuron index.
- in_spike  in  1  neuron fired.
- in_potential  in  32  final potential (float32 bits).
- pot_wr_en  out  1  potential write-back strobe.
- pot_wr_addr  out  NEURON_ID_W  write-back address.
- pot_wr_data  out  32  write-back data.
- pkt_valid  out  1  spike packet available.
- pkt_ready  in  1  network interface accepts packet.
- pkt_data  out  NODE_ID_W+NEURON_ID_W+TS_W  {node_id, neuron_id, ts}.
- ts_count  out  TS_W  current timestep.
- spike_count  out  16  spikes pushed since last clear; saturating.
- ts_done  out  1  one-cycle pulse when the timestep has fully drained.

Behaviour:
- Reset: FIFO empty, state ACCEPT; ts_count, spike_count, pot_wr_en, ts_done and pkt_valid all 0; pot_wr_addr and pot_wr_data 0.
- Accept: occurs when in_valid && in_ready. in_ready = (state==ACCEPT) && !fifo_full. in_ready never depends on in_valid.
- Write-back: registered, 1-cycle latency.
  - The cycle after an accept: pot_wr_en=1, addr=in_neuron_id, data=in_potential (bit-exact, no arithmetic).
  - Otherwise pot_wr_en=0. Write-back happens for every accepted update, spiking or not.
- Spike push: on accept with in_spike=1, push {node_id, in_neuron_id, ts_count} into the FIFO in the same edge.
  - spike_count increments and saturates at 0xFFFF.
- Packet output: pkt_valid = !fifo_empty. pkt_data is the FIFO head, stable while pkt_valid && !pkt_ready. Pop when pkt_valid && pkt_ready.
- Simultaneous push and pop: allowed whenever not full. Occupancy is unchanged and ordering is preserved. First-word latency is 1 cycle (the push edge, then pkt_valid).
- FIFO full: in_ready=0, so no push is possible and nothing is dropped. A pop while full frees the slot for the next cycle.
- FSM states:
  - ACCEPT: eot → DRAIN.
  - DRAIN: in_ready=0; stay until fifo_empty, then → DONE. If the FIFO is already empty on entry, DRAIN still lasts one cycle.
  - DONE: ts_done=1 for exactly one cycle, then → ACCEPT.
  - eot in DRAIN or DONE is ignored.
- clear, in any state: ts_count increments with wrap at 2^TS_W, and spike_count resets to 0.
  - An accept in the same cycle as clear uses the old ts_count, and its spike is not counted in the new spike_count.
  - clear does not flush the FIFO.
- clear and eot in the same cycle: both take effect.
- reset mid-operation: returns everything to the reset state immediately, discards FIFO contents, and suppresses any pending write-back.

Test Plan:
- Reset, node_id=3. Accept neuron 5 (spike=1, pot=0x3F000000) → next cycle pot_wr_en=1, addr=5, data=0x3F000000; pkt_valid=1, pkt_data={3,5,0}; spike_count=1.
- Non-spike update, neuron 7, pot=0x40400000 → write-back occurs; no packet; spike_count unchanged.
- pkt_ready=0, push 16 spikes (IDs 0..15) → in_ready=0 after the 16th. Raise pkt_ready → packets emerge in order 0..15 and in_ready returns to 1 after the first pop.
- 3 spikes queued with pkt_ready=0, then eot → in_ready=0. Release pkt_ready → after the 3rd pop, exactly one cycle of ts_done=1, then in_ready=1. eot with an empty FIFO → ts_done 2 cycles later.
- 256 clear pulses (TS_W=8) → ts_count wraps to 0. clear coincident with a spiking accept → packet ts = old value, spike_count=0.
- Assert reset while the FIFO holds 4 entries and a write-back is pending → next cycle pkt_valid=0, pot_wr_en=0, ts_count=0.
